// File: rtl/goal_plotter_pkg.sv
// Shared constants for the goal rectangle: widths, bounds, colours and plotter states.
// The collision checker imports the same bounds, so drawing and detection always agree.
package goal_plotter_pkg;

    localparam int COORD_W  = 9;
    localparam int COLOUR_W = 3;

    localparam logic [COORD_W-1:0] GOAL_X_MIN = 9'd5;
    localparam logic [COORD_W-1:0] GOAL_X_MAX = 9'd20;
    localparam logic [COORD_W-1:0] GOAL_Y_MIN = 9'd15;
    localparam logic [COORD_W-1:0] GOAL_Y_MAX = 9'd45;

    localparam logic [COLOUR_W-1:0] GOAL_COLOUR_DEF = 3'b000;
    localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plot_state_t;

endpackage

// File: rtl/goal_plotter_xy_scan_counter.sv
// Raster-order (x,y) scanner over an inclusive rectangle with a last-pixel flag.
// The end check is an equality compare, so bounds up to 511 never wrap.
module xy_scan_counter
    import goal_plotter_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_MIN = GOAL_X_MIN,
    parameter logic [COORD_W-1:0] X_MAX = GOAL_X_MAX,
    parameter logic [COORD_W-1:0] Y_MIN = GOAL_Y_MIN,
    parameter logic [COORD_W-1:0] Y_MAX = GOAL_Y_MAX
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    assign last = (x == X_MAX) && (y == Y_MAX);

    // Advancing past the last pixel is suppressed so the counter parks on it.
    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= X_MIN;
            y <= Y_MIN;
        end else if (advance && !last) begin
            if (x < X_MAX) begin
                x <= x + COORD_W'(1);
            end else begin
                x <= X_MIN;
                y <= y + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/goal_plotter.sv
// Paints the goal rectangle one pixel per handshake, in goal or background colour.
// Handshake: a pixel transfers on any cycle with plot=1 and ready=1; until then
// plot, x_out, y_out and colour hold. ready is ignored while plot=0.
module goal_plotter
    import goal_plotter_pkg::*;
#(
    parameter logic [COORD_W-1:0]  X_MIN       = GOAL_X_MIN,
    parameter logic [COORD_W-1:0]  X_MAX       = GOAL_X_MAX,
    parameter logic [COORD_W-1:0]  Y_MIN       = GOAL_Y_MIN,
    parameter logic [COORD_W-1:0]  Y_MAX       = GOAL_Y_MAX,
    parameter logic [COLOUR_W-1:0] GOAL_COLOUR = GOAL_COLOUR_DEF,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = BG_COLOUR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic                ready,
    output logic [COORD_W-1:0]  x_out,
    output logic [COORD_W-1:0]  y_out,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    plot_state_t state;
    logic        erase_latched;
    logic        load;
    logic        handshake;
    logic        last;

    assign load      = (state == IDLE) && start;
    assign handshake = (state == DRAW) && plot && ready;

    xy_scan_counter #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (handshake),
        .x       (x_out),
        .y       (y_out),
        .last    (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            erase_latched <= 1'b0;
            colour        <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        erase_latched <= erase;
                        colour        <= erase ? BG_COLOUR : GOAL_COLOUR;
                        plot          <= 1'b1;
                        busy          <= 1'b1;
                        state         <= DRAW;
                    end
                end
                DRAW: begin
                    // Colour follows the latched choice only, never the live erase input.
                    colour <= erase_latched ? BG_COLOUR : GOAL_COLOUR;
                    if (handshake && last) begin
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goal_plotter.sv
// Randomised self-checking bench for goal_plotter: a per-paint pixel list model
// compared every cycle, plus a degenerate 511x511 single-pixel instance.
module tb_goal_plotter;

    localparam int XMN  = 5;
    localparam int XMX  = 20;
    localparam int YMN  = 15;
    localparam int YMX  = 45;
    localparam int NPIX = (XMX - XMN + 1) * (YMX - YMN + 1);
    localparam int BUDGET = 3000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       erase = 1'b0;
    logic       ready = 1'b1;
    logic [8:0] x_out, y_out;
    logic [2:0] colour;
    logic       plot, busy, done;

    logic       start2 = 1'b0;
    logic       erase2 = 1'b0;
    logic       ready2 = 1'b0;
    logic [8:0] x2, y2;
    logic [2:0] colour2;
    logic       plot2, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: expected pixel list of the current paint and a coarse phase.
    logic [20:0] exp_q[$];
    int          phase = 0;          // 0 idle, 1 painting, 2 completion cycle
    bit          reset_fresh = 1'b1;
    int          done_count = 0;
    int          hs_in_paint = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_plot_cyc = -1;
    logic [20:0] first_px, last_px;

    goal_plotter dut (
        .clock (clock), .reset (reset), .start (start), .erase (erase), .ready (ready),
        .x_out (x_out), .y_out (y_out), .colour (colour),
        .plot (plot), .busy (busy), .done (done)
    );

    goal_plotter #(
        .X_MIN (9'd511), .X_MAX (9'd511), .Y_MIN (9'd511), .Y_MAX (9'd511)
    ) dut_one (
        .clock (clock), .reset (reset), .start (start2), .erase (erase2), .ready (ready2),
        .x_out (x2), .y_out (y2), .colour (colour2),
        .plot (plot2), .busy (busy2), .done (done2)
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare outputs against the model, then advance the model
    // using the inputs that the coming edge will sample.
    always @(negedge clock) begin
        cyc++;
        chk("plot", {31'd0, plot}, {31'd0, phase == 1});
        chk("busy", {31'd0, busy}, {31'd0, phase == 1});
        chk("done", {31'd0, done}, {31'd0, phase == 2});
        if (reset_fresh && phase == 0) begin
            chk("reset_xyc", {11'd0, x_out, y_out, colour}, 32'd0);
        end
        if (plot) begin
            chk("in_rect", {31'd0, (x_out >= XMN) && (x_out <= XMX) && (y_out >= YMN) && (y_out <= YMX)}, 32'd1);
            if (exp_q.size() > 0) begin
                chk("pixel", {11'd0, x_out, y_out, colour}, {11'd0, exp_q[0]});
            end else begin
                chk("pixel_unexpected", 32'd1, 32'd0);
            end
            if (first_plot_cyc < 0) first_plot_cyc = cyc;
            if (ready) begin
                if (hs_in_paint == 0) first_px = {x_out, y_out, colour};
                last_px = {x_out, y_out, colour};
                hs_in_paint++;
            end
        end
        if (done) done_count++;

        if (reset) begin
            phase = 0;
            exp_q.delete();
            reset_fresh = 1'b1;
        end else begin
            case (phase)
                0: if (start) begin
                    for (int yy = YMN; yy <= YMX; yy++)
                        for (int xx = XMN; xx <= XMX; xx++)
                            exp_q.push_back({9'(xx), 9'(yy), (erase ? 3'b111 : 3'b000)});
                    phase = 1;
                    reset_fresh = 1'b0;
                    hs_in_paint = 0;
                    start_cyc = cyc;
                    first_plot_cyc = -1;
                end
                1: if (ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) phase = 2;
                end
                default: phase = 0;
            endcase
        end
    end

    // Driver: pulse start, then run the handshake loop in the chosen ready mode.
    // mode 0: ready=1; 1: ready toggles 1,0; 2: random ready plus erase/start noise; 3: random ready.
    task automatic paint(input logic er, input int mode, input int abort_at, output int cycles);
        int d0;
        d0 = done_count;
        cycles = 0;
        start = 1'b1;
        erase = er;
        tick();
        start = 1'b0;
        while (done_count == d0 && cycles < BUDGET) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = (cycles % 2 == 0);
                2: begin
                    ready = ($urandom_range(0, 3) != 0);
                    erase = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            if (abort_at > 0 && hs_in_paint >= abort_at) break;
            tick();
            cycles++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (abort_at == 0) begin
            chk("paint_in_budget", {31'd0, cycles < BUDGET}, 32'd1);
            tick();
            tick();
            chk("one_done", 32'(done_count - d0), 32'd1);
            chk("pixel_count", 32'(hs_in_paint), 32'(NPIX));
        end
    endtask

    initial begin
        int cycles;
        int d0;

        tick();
        tick();
        reset = 1'b0;
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_xyc", {11'd0, x_out, y_out, colour}, 32'd0);
        tick();

        // Full paint, ready always high
        paint(1'b0, 0, 0, cycles);
        chk("first_px", {11'd0, first_px}, {11'd0, 9'd5, 9'd15, 3'b000});
        chk("last_px", {11'd0, last_px}, {11'd0, 9'd20, 9'd45, 3'b000});
        chk("first_latency", 32'(first_plot_cyc - start_cyc), 32'd1);
        chk("streaming_cycles", 32'(cycles), 32'(NPIX + 1));

        // Ready toggling 1,0
        paint(1'b0, 1, 0, cycles);
        chk("toggle_last_px", {11'd0, last_px}, {11'd0, 9'd20, 9'd45, 3'b000});

        // Erase paint with erase flips and start noise during DRAW
        paint(1'b1, 2, 0, cycles);
        chk("erase_first_px", {11'd0, first_px}, {11'd0, 9'd5, 9'd15, 3'b111});
        chk("erase_last_px", {11'd0, last_px}, {11'd0, 9'd20, 9'd45, 3'b111});

        // Abort at pixel 100 with reset, then an immediate fresh paint
        d0 = done_count;
        paint(1'b0, 0, 100, cycles);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_plot", {31'd0, plot}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_no_done", 32'(done_count - d0), 32'd0);
        paint(1'b0, 3, 0, cycles);
        chk("restart_first_px", {11'd0, first_px}, {11'd0, 9'd5, 9'd15, 3'b000});

        // A few random paints
        for (int i = 0; i < 3; i++) begin
            paint(1'($urandom_range(0, 1)), 3, 0, cycles);
        end

        // Degenerate single-pixel region at 511,511
        ready2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("one_plot", {31'd0, plot2}, 32'd1);
        chk("one_busy", {31'd0, busy2}, 32'd1);
        chk("one_xy", {14'd0, x2, y2}, {14'd0, 9'd511, 9'd511});
        tick();
        tick();
        chk("one_hold", {13'd0, plot2, x2, y2}, {13'd0, 1'b1, 9'd511, 9'd511});
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        chk("one_plot_off", {31'd0, plot2}, 32'd0);
        chk("one_done", {31'd0, done2}, 32'd1);
        chk("one_busy_off", {31'd0, busy2}, 32'd0);
        chk("one_no_wrap", {14'd0, x2, y2}, {14'd0, 9'd511, 9'd511});
        tick();
        chk("one_done_off", {30'd0, done2, plot2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/goal_plotter.md
GOAL_PLOTTER -- requirements
Module: goal_plotter

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset, with ports named clock and reset.
REQ-002 Parameter X_MIN, default 9'd5, SHALL set the left goal column, inclusive.
REQ-003 Parameter X_MAX, default 9'd20, SHALL set the right goal column, inclusive.
REQ-004 Parameter Y_MIN, default 9'd15, SHALL set the top goal row, inclusive.
REQ-005 Parameter Y_MAX, default 9'd45, SHALL set the bottom goal row, inclusive.
REQ-006 Parameter GOAL_COLOUR, default 3'b000, SHALL set the colour used when drawing.
REQ-007 Parameter BG_COLOUR, default 3'b111, SHALL set the colour used when erasing.
REQ-008 Ports SHALL be, in this order:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  request one full paint of the goal rectangle
- erase  in  1  sampled with start: 1 = paint BG_COLOUR, 0 = paint GOAL_COLOUR
- ready  in  1  pixel sink accepts the current pixel this cycle
- x_out  out 9  current pixel column
- y_out  out 9  current pixel row
- colour out 3  current pixel colour
- plot   out 1  current pixel is valid
- busy   out 1  a paint is in progress
- done   out 1  one-cycle pulse when a paint completes

Function
REQ-009 The FSM SHALL have three states, IDLE, DRAW and DONE, and all outputs SHALL be registered.
REQ-010 In IDLE with start=1, the block SHALL latch erase, load x=X_MIN and y=Y_MIN, and enter DRAW on the next edge; plot SHALL assert on the cycle after start is sampled.
REQ-011 In DRAW, plot, x_out, y_out and colour SHALL be held stable until a cycle with plot=1 and ready=1 (a handshake).
REQ-012 On each handshake, the block SHALL advance in raster order:
- x+1 if x<X_MAX;
- otherwise x=X_MIN and y+1.
REQ-013 A handshake at x=X_MAX, y=Y_MAX SHALL deassert plot and enter DONE; the block SHALL never emit a coordinate outside the rectangle.
REQ-014 DONE SHALL last exactly one cycle with done=1, busy=0 and plot=0, then return to IDLE.
REQ-015 busy SHALL be 1 in DRAW and 0 in IDLE and DONE.
REQ-016 start SHALL be ignored in DRAW and in DONE; it is not queued.
REQ-017 colour SHALL be BG_COLOUR if the latched erase=1, else GOAL_COLOUR, constant for the whole paint; a change on erase mid-paint SHALL have no effect.
REQ-018 With ready held at 1, a paint SHALL emit exactly (X_MAX-X_MIN+1)*(Y_MAX-Y_MIN+1) pixels, 496 with the defaults, on consecutive cycles, followed by done on the next cycle.
REQ-019 With ready=0, the block SHALL stall indefinitely without skipping or duplicating a pixel.
REQ-020 A degenerate region with X_MIN=X_MAX and Y_MIN=Y_MAX SHALL emit exactly one pixel and then done.
REQ-021 Coordinate arithmetic SHALL be 9-bit unsigned; X_MAX and Y_MAX up to 9'd511 SHALL not wrap, because the end check is an equality compare done before the increment.

Reset
REQ-022 On reset, the block SHALL go to IDLE with x_out=0, y_out=0, colour=0, plot=0, busy=0, done=0, and latched erase=0.
REQ-023 Reset asserted mid-paint SHALL abort on the next edge with no done pulse; a start on the cycle after reset deasserts SHALL begin a fresh paint from (X_MIN,Y_MIN).
REQ-024 Reset SHALL take priority over start and over ready.

Structure
REQ-025 A shared package SHALL hold:
- the coordinate width (9) and colour width (3);
- the goal rectangle bounds and the colour constants, shared with the goal collision checker so that drawing and detection agree;
- the FSM state enum.
REQ-026 A single sub-module, xy_scan_counter, SHALL implement the parameterised raster counter (load, advance enable, last-pixel flag); the FSM SHALL stay in goal_plotter.

Verification
REQ-027 Default parameters, ready=1, start pulse with erase=0: plot first at (5,15) one cycle after start, last at (20,45), 496 plots with colour 000, done one cycle later, busy high throughout.
REQ-028 Same, but with ready toggling 1,0 each cycle: the same 496 unique coordinates in raster order, each held while ready=0, and done after the last accepted pixel.
REQ-029 start with erase=1, then erase driven to 0 and start re-pulsed during DRAW: every pixel has colour 111, the paint is not restarted, and exactly one done pulse occurs.
REQ-030 reset asserted at pixel 100: plot, busy and done are 0 on the next cycle with no done pulse; a following start restarts at (5,15) and completes 496 pixels.
REQ-031 X_MIN=X_MAX=Y_MIN=Y_MAX=511: one plot at (511,511), then done, with no wrap to 0.
REQ-032 A bench scoreboard SHALL check every emitted pixel against the region and collision test: all plotted coordinates satisfy X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX.
